// File: rtl/shift_pkg.sv
// Shared encodings for the parametrised shift register: shift modes,
// directions and the controller state enum.
package shift_pkg;

  localparam logic [1:0] SH_LOGIC  = 2'b00;
  localparam logic [1:0] SH_ARITH  = 2'b01;
  localparam logic [1:0] SH_ROT    = 2'b10;
  localparam logic [1:0] SH_SERIAL = 2'b11;

  localparam logic SH_RIGHT = 1'b0;
  localparam logic SH_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Purely combinational single-position shift: produces the next register
// value and the bit that leaves the register on this step.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic             ser_in_i,
  output logic [WIDTH-1:0] q_o,
  output logic             exit_o
);

  logic exit_bit;
  logic fill;

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no path can infer a latch.
    exit_bit = (dir_i == SH_LEFT) ? q_i[WIDTH-1] : q_i[0];
    fill     = 1'b0;
    case (mode_i)
      SH_ARITH:  fill = (dir_i == SH_RIGHT) ? q_i[WIDTH-1] : 1'b0;
      SH_ROT:    fill = exit_bit;
      SH_SERIAL: fill = ser_in_i;
      default:   fill = 1'b0;
    endcase
  end

  assign q_o    = (dir_i == SH_LEFT) ? {q_i[WIDTH-2:0], fill} : {fill, q_i[WIDTH-1:1]};
  assign exit_o = exit_bit;

endmodule

// File: rtl/param_shift_reg.sv
// WIDTH-bit multi-mode shift register with a busy/done handshake, shifting
// one position per clock. Define SHIFT_STICKY_EN to build the sticky accumulator.
module param_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic             sticky
);

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] step_d;
  logic             exit_bit;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] amt_d;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic             ser_out_q;
  logic             busy_q;
  logic             done_q;
  logic             accept_start;

  assign accept_start = (state_q == IDLE) && start && !load;
  assign amt_d        = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q_i      (q_q),
    .dir_i    (dir_q),
    .mode_i   (mode_q),
    .ser_in_i (ser_in),
    .q_o      (step_d),
    .exit_o   (exit_bit)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      q_q       <= '0;
      cnt_q     <= '0;
      dir_q     <= SH_RIGHT;
      mode_q    <= SH_LOGIC;
      ser_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            q_q <= load_val;
          end else if (accept_start) begin
            dir_q  <= dir;
            mode_q <= mode;
            cnt_q  <= amt_d;
            if (amt_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          q_q       <= step_d;
          ser_out_q <= exit_bit;
          cnt_q     <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_STICKY_EN
  logic sticky_q;

  // Accumulates every bit that leaves the register during the current operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else if (accept_start) begin
      sticky_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      sticky_q <= sticky_q | exit_bit;
    end
  end

  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;
`endif

  assign q       = q_q;
  assign ser_out = ser_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_param_shift_reg.sv
// Self-checking bench for param_shift_reg: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_param_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

`ifdef SHIFT_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [W-1:0]  load_val;
  logic          start;
  logic [CW-1:0] shamt;
  logic          dir;
  logic [1:0]    mode;
  logic          ser_in;
  logic [W-1:0]  q;
  logic          ser_out;
  logic          busy;
  logic          done;
  logic          sticky;

  int checks   = 0;
  int failures = 0;

  param_shift_reg #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .shamt    (shamt),
    .dir      (dir),
    .mode     (mode),
    .ser_in   (ser_in),
    .q        (q),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done),
    .sticky   (sticky)
  );

  always #5 clk = ~clk;

  // Final register value after n single-position shifts, written as whole-word arithmetic.
  function automatic logic [W-1:0] model_q(input logic [W-1:0] v, input int n, input logic d,
                                           input logic [1:0] m, input logic s);
    logic [W-1:0] ones;
    ones = '1;
    if (d == 1'b0) begin
      case (m)
        2'b00:   return v >> n;
        2'b01:   return $signed(v) >>> n;
        2'b10:   return (v >> n) | (v << (W - n));
        default: return (v >> n) | (s ? ~(ones >> n) : '0);
      endcase
    end else begin
      case (m)
        2'b00, 2'b01: return v << n;
        2'b10:        return (v << n) | (v >> (W - n));
        default:      return (v << n) | (s ? ~(ones << n) : '0);
      endcase
    end
  endfunction

  // Bits leaving the register are always original bits: the low n (right) or high n (left).
  function automatic logic model_last_out(input logic [W-1:0] v, input int n, input logic d);
    return (d == 1'b0) ? v[n-1] : v[W-n];
  endfunction

  function automatic logic model_sticky(input logic [W-1:0] v, input int n, input logic d);
    logic [W-1:0] ones;
    ones = '1;
    if (!STICKY_ON) return 1'b0;
    return (d == 1'b0) ? |(v & ~(ones << n)) : |(v & ~(ones >> n));
  endfunction

  task automatic do_load(input logic [W-1:0] v);
    @(negedge clk);
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Issues a start, scrambles the operation inputs during the shift, and returns at the done cycle.
  task automatic run_op(input int n, input logic d, input logic [1:0] m, input logic s,
                        output int busy_cnt, output int done_cyc);
    @(negedge clk);
    start  = 1'b1;
    shamt  = CW'(n);
    dir    = d;
    mode   = m;
    ser_in = s;
    @(negedge clk);
    start    = 1'b0;
    shamt    = CW'($urandom_range(0, (1 << CW) - 1));
    dir      = 1'($urandom_range(0, 1));
    mode     = 2'($urandom_range(0, 3));
    busy_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      if (c < 40) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; load = 1'b0; load_val = '0; start = 1'b0;
    shamt = '0; dir = 1'b0; mode = 2'b00; ser_in = 1'b0;
    #12;
    checks++; if (q !== '0)        begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
    checks++; if (ser_out !== 1'b0) begin failures++; $display("FAIL reset_ser_out got=%b exp=0", ser_out); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)    begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sticky !== 1'b0)  begin failures++; $display("FAIL reset_sticky got=%b exp=0", sticky); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_arith_right;
    int bc, dc;
    do_load(8'b1001_0110);
    run_op(3, 1'b0, 2'b01, 1'b0, bc, dc);
    checks++; if (dc !== 4)          begin failures++; $display("FAIL arith_done_cycle got=%0d exp=4", dc); end
    checks++; if (bc !== 3)          begin failures++; $display("FAIL arith_busy_cycles got=%0d exp=3", bc); end
    checks++; if (q !== 8'b1111_0010) begin failures++; $display("FAIL arith_q got=%b exp=11110010", q); end
    checks++; if (ser_out !== 1'b1)  begin failures++; $display("FAIL arith_ser_out got=%b exp=1", ser_out); end
    checks++; if (sticky !== STICKY_ON) begin failures++; $display("FAIL arith_sticky got=%b exp=%b", sticky, STICKY_ON); end
    @(negedge clk);
    checks++; if (done !== 1'b0)     begin failures++; $display("FAIL arith_done_width got=%b exp=0", done); end
  endtask

  task automatic test_rotate;
    int bc, dc;
    do_load(8'hA5);
    run_op(4, 1'b1, 2'b10, 1'b0, bc, dc);
    checks++; if (q !== 8'h5A) begin failures++; $display("FAIL rot4_q got=%h exp=5a", q); end
    checks++; if (dc !== 5)    begin failures++; $display("FAIL rot4_done_cycle got=%0d exp=5", dc); end
    run_op(8, 1'b1, 2'b10, 1'b0, bc, dc);
    checks++; if (q !== 8'h5A) begin failures++; $display("FAIL rot8_q got=%h exp=5a", q); end
    checks++; if (dc !== 9)    begin failures++; $display("FAIL rot8_done_cycle got=%0d exp=9", dc); end
    checks++; if (bc !== 8)    begin failures++; $display("FAIL rot8_busy_cycles got=%0d exp=8", bc); end
  endtask

  task automatic test_clamp;
    int bc, dc;
    do_load(8'hFF);
    run_op(12, 1'b1, 2'b00, 1'b0, bc, dc);
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL clamp_q got=%h exp=00", q); end
    checks++; if (dc !== 9)    begin failures++; $display("FAIL clamp_done_cycle got=%0d exp=9", dc); end
    checks++; if (bc !== 8)    begin failures++; $display("FAIL clamp_busy_cycles got=%0d exp=8", bc); end
  endtask

  task automatic test_zero_and_priority;
    int bc, dc;
    bit bad;
    do_load(8'h3C);
    run_op(0, 1'b0, 2'b00, 1'b0, bc, dc);
    checks++; if (dc !== 1)    begin failures++; $display("FAIL zero_done_cycle got=%0d exp=1", dc); end
    checks++; if (bc !== 0)    begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=0", bc); end
    checks++; if (q !== 8'h3C) begin failures++; $display("FAIL zero_q got=%h exp=3c", q); end
    @(negedge clk);
    load = 1'b1; load_val = 8'h77; start = 1'b1; shamt = CW'(3); dir = 1'b0; mode = 2'b00;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    checks++; if (q !== 8'h77) begin failures++; $display("FAIL prio_q got=%h exp=77", q); end
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL prio_no_op got=%b exp=0", bad); end
  endtask

  task automatic test_serial_ignore_load;
    int dc;
    do_load(8'h00);
    @(negedge clk);
    start = 1'b1; shamt = CW'(2); dir = 1'b0; mode = 2'b11; ser_in = 1'b1;
    @(negedge clk);
    start = 1'b0; load = 1'b1; load_val = 8'hFF;
    dc = 0;
    for (int c = 1; c <= 10; c++) begin
      if (done === 1'b1) begin
        dc = c;
        break;
      end
      @(negedge clk);
    end
    checks++; if (dc !== 3)    begin failures++; $display("FAIL serial_done_cycle got=%0d exp=3", dc); end
    checks++; if (q !== 8'hC0) begin failures++; $display("FAIL serial_q got=%h exp=c0", q); end
    @(negedge clk);
    checks++; if (q !== 8'hC0) begin failures++; $display("FAIL serial_load_ignored got=%h exp=c0", q); end
    load = 1'b0; ser_in = 1'b0;
  endtask

  task automatic test_reset_mid_shift;
    bit seen;
    do_load(8'h5B);
    @(negedge clk);
    start = 1'b1; shamt = CW'(5); dir = 1'b0; mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    #1 reset = 1'b1;
    #1;
    checks++; if (q !== '0)      begin failures++; $display("FAIL midrst_q got=%h exp=00", q); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_done got=%b exp=0", seen); end
  endtask

  task automatic test_random;
    int bc, dc, n, ne;
    logic [W-1:0] v, exp_q;
    logic d, s, exp_ser, exp_st;
    logic [1:0] m;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    exp_ser = 1'b0;
    for (int i = 0; i < 40; i++) begin
      v  = W'($urandom_range(0, (1 << W) - 1));
      n  = $urandom_range(0, (1 << CW) - 1);
      d  = 1'($urandom_range(0, 1));
      m  = 2'($urandom_range(0, 3));
      s  = 1'($urandom_range(0, 1));
      ne = (n > W) ? W : n;
      exp_q  = model_q(v, ne, d, m, s);
      exp_st = model_sticky(v, ne, d);
      if (ne > 0) exp_ser = model_last_out(v, ne, d);
      do_load(v);
      run_op(n, d, m, s, bc, dc);
      checks++; if (q !== exp_q)       begin failures++; $display("FAIL rnd_q i=%0d v=%h n=%0d d=%b m=%b got=%h exp=%h", i, v, n, d, m, q, exp_q); end
      checks++; if (ser_out !== exp_ser) begin failures++; $display("FAIL rnd_ser_out i=%0d got=%b exp=%b", i, ser_out, exp_ser); end
      checks++; if (sticky !== exp_st) begin failures++; $display("FAIL rnd_sticky i=%0d got=%b exp=%b", i, sticky, exp_st); end
      checks++; if (bc !== ne)         begin failures++; $display("FAIL rnd_busy_cycles i=%0d got=%0d exp=%0d", i, bc, ne); end
      checks++; if (dc !== ne + 1)     begin failures++; $display("FAIL rnd_done_cycle i=%0d got=%0d exp=%0d", i, dc, ne + 1); end
      @(negedge clk);
      checks++; if (done !== 1'b0)     begin failures++; $display("FAIL rnd_done_width i=%0d got=%b exp=0", i, done); end
    end
  endtask

  initial begin
    test_reset();
    test_arith_right();
    test_rotate();
    test_clamp();
    test_zero_and_priority();
    test_serial_ignore_load();
    test_reset_mid_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
